// File: rtl/l2_port_arb_if.sv
// Bundle of the three ports the L2 arbiter connects: the L1i refill port,
// the L1d refill/writeback port and the single hmem (L2) port.
interface l2_port_arb_if #(
  parameter int ADDR_W = 64,
  parameter int LINE   = 256
);
  // L1i refill side
  logic [ADDR_W-1:0] i_addr;
  logic              i_rd;
  logic [LINE-1:0]   i_data;
  logic              i_dv;
  // L1d refill / writeback side
  logic [ADDR_W-1:0] d_addr;
  logic              d_rd;
  logic              d_wr;
  logic [LINE-1:0]   d_wdata;
  logic [LINE-1:0]   d_rdata;
  logic              d_dv;
  logic              amo_lock;
  // L2 side
  logic [ADDR_W-1:0] m_addr;
  logic              m_rd;
  logic              m_wr;
  logic [LINE-1:0]   m_wdata;
  logic [LINE-1:0]   m_rdata;
  logic              m_dv;
  logic              busy;

  // Arbiter view
  modport slave (
    input  i_addr, i_rd,
    output i_data, i_dv,
    input  d_addr, d_rd, d_wr, d_wdata,
    output d_rdata, d_dv,
    input  amo_lock,
    output m_addr, m_rd, m_wr, m_wdata,
    input  m_rdata, m_dv,
    output busy
  );

  // Environment view (L1 caches plus L2 memory)
  modport master (
    output i_addr, i_rd,
    input  i_data, i_dv,
    output d_addr, d_rd, d_wr, d_wdata,
    input  d_rdata, d_dv,
    output amo_lock,
    input  m_addr, m_rd, m_wr, m_wdata,
    output m_rdata, m_dv,
    input  busy
  );
endinterface

// File: rtl/l2_port_arb.sv
// l2_port_arb: shares the single L2 refill/write port between L1i refills and
// L1d refills/writebacks. One transaction at a time, round-robin between I and
// D, with an AMO lock that keeps the I side from being newly granted.
module l2_port_arb #(
  parameter int ADDR_W = 64,
  parameter int LINE   = 256
) (
  input  logic          clk,
  input  logic          rst,
  l2_port_arb_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_I  = 3'd1,
    GNT_DR = 3'd2,
    GNT_DW = 3'd3,
    REL    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;        // 0: I preferred, 1: D preferred
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [LINE-1:0]   m_wdata_q, m_wdata_d;
  logic              m_rd_q, m_rd_d;
  logic              m_wr_q, m_wr_d;

  logic req_i;
  logic req_d;
  logic pick_i;

  // Request qualification: the AMO lock masks only the I side.
  always_comb begin
    req_i  = bus.i_rd & ~bus.amo_lock;
    req_d  = bus.d_rd | bus.d_wr;
    pick_i = req_i & (~req_d | ~rr_q);
  end

  // State and L2 strobe/address registers; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold the L2 request until m_dv, then
  // spend one release cycle so a still-held request is not re-granted.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_rd_d    = m_rd_q;
    m_wr_d    = m_wr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d  = GNT_I;
          m_addr_d = bus.i_addr;
          m_rd_d   = 1'b1;
        end else if (req_d) begin
          m_addr_d = bus.d_addr;
          if (bus.d_wr) begin
            // A write outranks a simultaneous D refill request.
            state_d   = GNT_DW;
            m_wdata_d = bus.d_wdata;
            m_wr_d    = 1'b1;
          end else begin
            state_d = GNT_DR;
            m_rd_d  = 1'b1;
          end
        end
      end
      GNT_I, GNT_DR, GNT_DW: begin
        if (bus.m_dv) begin
          state_d = REL;
          m_rd_d  = 1'b0;
          m_wr_d  = 1'b0;
          rr_d    = (state_q == GNT_I);
        end
      end
      REL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        m_rd_d  = 1'b0;
        m_wr_d  = 1'b0;
      end
    endcase
  end

  // Completion is combinational: L2 data is broadcast and the owner's
  // done pulse follows m_dv in the same cycle.
  always_comb begin
    bus.i_data  = bus.m_rdata;
    bus.d_rdata = bus.m_rdata;
    bus.i_dv    = bus.m_dv & (state_q == GNT_I);
    bus.d_dv    = bus.m_dv & ((state_q == GNT_DR) | (state_q == GNT_DW));
    bus.m_addr  = m_addr_q;
    bus.m_wdata = m_wdata_q;
    bus.m_rd    = m_rd_q;
    bus.m_wr    = m_wr_q;
    bus.busy    = (state_q != IDLE);
  end

endmodule

// File: tb/tb_l2_port_arb.sv
// Bench for l2_port_arb: transaction-level model checked every cycle, an
// L2 responder with programmable latency, L1 requesters that drop their
// request after their done pulse, and directed scenarios with literal checks.
module tb_l2_port_arb;
  localparam int ADDR_W = 64;
  localparam int LINE   = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l2_port_arb_if #(.ADDR_W(ADDR_W), .LINE(LINE)) ifc ();

  l2_port_arb #(.ADDR_W(ADDR_W), .LINE(LINE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [LINE-1:0] got, input logic [LINE-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // owner: 0 none, 1 I read, 2 D read, 3 D write; rel marks the release cycle.
  int                mo_owner;
  bit                mo_rel;
  bit                mo_rr;
  bit                mo_ireq, mo_dreq;
  logic [ADDR_W-1:0] mo_addr;
  logic [LINE-1:0]   mo_wdata;
  logic [LINE-1:0]   l2_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mo_owner = 0; mo_rel = 0; mo_rr = 0; mo_addr = '0; mo_wdata = '0;
    end else if (mo_owner != 0) begin
      if (ifc.m_dv === 1'b1) begin
        mo_rr    = (mo_owner == 1);
        mo_owner = 0;
        mo_rel   = 1;
      end
    end else if (mo_rel) begin
      mo_rel = 0;
    end else begin
      mo_ireq = ifc.i_rd && !ifc.amo_lock;
      mo_dreq = ifc.d_rd || ifc.d_wr;
      if (mo_ireq && (!mo_dreq || !mo_rr)) begin
        mo_owner = 1; mo_addr = ifc.i_addr;
      end else if (mo_dreq) begin
        mo_addr = ifc.d_addr;
        if (ifc.d_wr) begin mo_owner = 3; mo_wdata = ifc.d_wdata; end
        else mo_owner = 2;
      end
    end
  end

  // ---------------- per-cycle compare + statistics ----------------
  int              n_rd, n_wr, n_idv, n_ddv;
  logic [ADDR_W-1:0] glog[$];
  bit              prev_strobe = 0;

  always @(negedge clk) begin
    chk("m_rd",    ifc.m_rd,    (mo_owner == 1 || mo_owner == 2));
    chk("m_wr",    ifc.m_wr,    (mo_owner == 3));
    chk("busy",    ifc.busy,    (mo_owner != 0 || mo_rel));
    chk("i_dv",    ifc.i_dv,    (ifc.m_dv && mo_owner == 1));
    chk("d_dv",    ifc.d_dv,    (ifc.m_dv && mo_owner >= 2));
    chk("m_addr",  ifc.m_addr,  mo_addr);
    chk("m_wdata", ifc.m_wdata, mo_wdata);
    if (ifc.i_dv) chk("i_data",  ifc.i_data,  l2_data);
    if (ifc.d_dv) chk("d_rdata", ifc.d_rdata, l2_data);
    if (ifc.m_rd) n_rd++;
    if (ifc.m_wr) n_wr++;
    if (ifc.i_dv) n_idv++;
    if (ifc.d_dv) n_ddv++;
    if ((ifc.m_rd || ifc.m_wr) && !prev_strobe) glog.push_back(ifc.m_addr);
    prev_strobe = ifc.m_rd || ifc.m_wr;
  end

  // ---------------- environment ----------------
  int lat     = 4;
  int cnt     = 0;
  bit auto_l2 = 1;

  function automatic logic [LINE-1:0] rnd_line();
    logic [LINE-1:0] r;
    for (int i = 0; i < LINE / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    bit idv, ddv;
    @(negedge clk);
    idv = ifc.i_dv;
    ddv = ifc.d_dv;
    @(posedge clk);
    #1;
    if (idv) ifc.i_rd = 1'b0;
    if (ddv) begin ifc.d_rd = 1'b0; ifc.d_wr = 1'b0; end
    if (auto_l2) begin
      if (ifc.m_dv) begin
        ifc.m_dv = 1'b0;
        cnt = 0;
      end else if (ifc.m_rd || ifc.m_wr) begin
        cnt++;
        if (cnt == lat) begin
          l2_data     = rnd_line();
          ifc.m_rdata = l2_data;
          ifc.m_dv    = 1'b1;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    n_rd = 0; n_wr = 0; n_idv = 0; n_ddv = 0;
    glog.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.i_rd = 0; ifc.d_rd = 0; ifc.d_wr = 0; ifc.amo_lock = 0; ifc.m_dv = 0;
    cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [LINE-1:0] pat_a5;

  initial begin
    ifc.i_addr = '0; ifc.i_rd = 0; ifc.d_addr = '0; ifc.d_rd = 0; ifc.d_wr = 0;
    ifc.d_wdata = '0; ifc.amo_lock = 0; ifc.m_rdata = '0; ifc.m_dv = 0;
    l2_data = '0;
    clr();
    do_reset();
    tick();
    chk("rst_busy",  ifc.busy,   1'b0);
    chk("rst_m_rd",  ifc.m_rd,   1'b0);
    chk("rst_m_wr",  ifc.m_wr,   1'b0);
    chk("rst_maddr", ifc.m_addr, '0);

    // I only, L2 answers in the 4th strobe cycle
    lat = 4; clr();
    ifc.i_addr = 64'h1000; ifc.i_rd = 1;
    run(12);
    chk("t1_rd_cycles", n_rd, 4);
    chk("t1_idv",       n_idv, 1);
    chk("t1_ddv",       n_ddv, 0);
    chk("t1_addr",      glog[0], 64'h1000);

    // Simultaneous after reset: I, D, then I, D again; then rr=1 case
    do_reset(); lat = 2; clr();
    ifc.i_addr = 64'h2000; ifc.d_addr = 64'h3000; ifc.i_rd = 1; ifc.d_rd = 1;
    run(14);
    ifc.i_addr = 64'h2100; ifc.d_addr = 64'h3100; ifc.i_rd = 1; ifc.d_rd = 1;
    run(14);
    ifc.i_addr = 64'h2200; ifc.i_rd = 1;
    run(8);
    ifc.i_addr = 64'h2300; ifc.d_addr = 64'h3300; ifc.i_rd = 1; ifc.d_rd = 1;
    run(14);
    chk("t2_n",  glog.size(), 7);
    chk("t2_g0", glog[0], 64'h2000);
    chk("t2_g1", glog[1], 64'h3000);
    chk("t2_g2", glog[2], 64'h2100);
    chk("t2_g3", glog[3], 64'h3100);
    chk("t2_g4", glog[4], 64'h2200);
    chk("t2_g5", glog[5], 64'h3300);
    chk("t2_g6", glog[6], 64'h2300);

    // Write priority over simultaneous D read
    lat = 4; clr();
    pat_a5 = {8{32'hA5A5A5A5}};
    ifc.d_addr = 64'h7000; ifc.d_wdata = pat_a5; ifc.d_rd = 1; ifc.d_wr = 1;
    run(10);
    chk("t3_wr_cycles", n_wr, 4);
    chk("t3_rd_cycles", n_rd, 0);
    chk("t3_ddv",       n_ddv, 1);
    chk("t3_wdata",     ifc.m_wdata, pat_a5);

    // AMO lock: only D granted while locked, I follows once released
    do_reset(); lat = 3; clr();
    ifc.amo_lock = 1; ifc.i_addr = 64'h4000; ifc.i_rd = 1;
    ifc.d_addr = 64'h5000; ifc.d_rd = 1;
    run(10);
    ifc.d_addr = 64'h5100; ifc.d_rd = 1;
    run(10);
    chk("t4_idv_locked", n_idv, 0);
    ifc.amo_lock = 0;
    run(10);
    chk("t4_n",   glog.size(), 3);
    chk("t4_g0",  glog[0], 64'h5000);
    chk("t4_g1",  glog[1], 64'h5100);
    chk("t4_g2",  glog[2], 64'h4000);
    chk("t4_idv", n_idv, 1);
    chk("t4_ddv", n_ddv, 2);

    // Asynchronous reset in the middle of a D read
    do_reset(); auto_l2 = 0; clr();
    ifc.d_addr = 64'h6000; ifc.d_rd = 1;
    run(2);
    chk("t5_pre_rd", ifc.m_rd, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rd",   ifc.m_rd,   1'b0);
    chk("t5_busy", ifc.busy,   1'b0);
    chk("t5_addr", ifc.m_addr, '0);
    ifc.d_rd = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    l2_data = rnd_line(); ifc.m_rdata = l2_data; ifc.m_dv = 1;
    tick();
    ifc.m_dv = 0;
    tick();
    chk("t5_ddv",  n_ddv, 0);
    chk("t5_busy2", ifc.busy, 1'b0);

    // Stray m_dv while idle
    clr();
    ifc.m_dv = 1;
    tick();
    ifc.m_dv = 0;
    tick();
    chk("t6_idv",  n_idv, 0);
    chk("t6_ddv",  n_ddv, 0);
    chk("t6_busy", ifc.busy, 1'b0);
    auto_l2 = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
